bit_serial_adder: RTL and testbench
===================================

// Module: bit_serial_adder
// PURPOSE
//   Parametrised bit-serial adder. Successor to the 4-bit combinational adder.
//   Latches two WIDTH-bit operands and a carry-in on a valid/ready handshake.
//   Adds them BITS_PER_CYCLE bits per clock, LSB slice first, through one small slice adder.
//   Holds the sum and carry-out until the consumer accepts them.
//   Sits between the operand register file and the result bus in the arithmetic datapath.
// PARAMETERS
//   WIDTH           8   operand/sum width in bits; >= 2
//   BITS_PER_CYCLE  1   slice width per clock; must divide WIDTH (elaboration error otherwise)
// PORTS
//   Clock        in   1      single clock, all state on rising edge
//   ResetN       in   1      asynchronous, active-low reset
//   InputValid   in   1      operands presented
//   InputReady   out  1      block can accept operands (high only in IDLE)
//   InputA       in   WIDTH  operand A
//   InputB       in   WIDTH  operand B
//   InputCarry   in   1      carry-in
//   OutputValid  out  1      Output/OutputCarry/Overflow valid (high only in DONE)
//   OutputReady  in   1      consumer accepts result
//   Output       out  WIDTH  sum[WIDTH-1:0]
//   OutputCarry  out  1      unsigned carry-out of MSB
//   Overflow     out  1      signed overflow (carry into MSB XOR carry out of MSB)
// BEHAVIOUR
//   Reset (ResetN=0, asynchronous): state=IDLE, InputReady=1, OutputValid=0, Output=0.
//     Also OutputCarry=0, Overflow=0, slice counter=0, internal carry=0.
//   FSM, three states:
//     IDLE: on InputValid&&InputReady, capture A, B, carry; go to RUN; InputReady drops next cycle.
//     RUN: each cycle add slice k (bits k*BPC +: BPC) of A, B and the running carry.
//       Shift the result into the sum register from the MSB end.
//       After N=WIDTH/BITS_PER_CYCLE cycles go to DONE.
//     DONE: OutputValid=1; outputs stable. On OutputReady go to IDLE.
//   Latency: accept edge to OutputValid high = N+1 clocks (WIDTH=8, BPC=1 -> 9).
//   Throughput: one result per N+2 clocks when OutputReady is held high.
//   No skid: a new operand is accepted only in IDLE, never on the DONE->IDLE edge.
//   Backpressure: DONE holds indefinitely while OutputReady=0; outputs must not change.
//   InputValid is ignored outside IDLE; the operands must not be re-sampled.
//   Output, OutputCarry and Overflow are registered. They are undefined-free and update only on entering DONE.
//   Overflow is computed on the final slice only: carry into bit WIDTH-1 XOR OutputCarry.
//   Reset mid-RUN or mid-DONE: immediate return to reset values; the partial result is discarded.
//   Arithmetic is modulo 2^WIDTH. Carry-out is bit WIDTH of A+B+Cin.
// CONFIGURATION
//   BIT_SERIAL_ADDER_SUB_EN defined:
//     Adds input port Subtract (1 bit), captured with the operands.
//     When Subtract=1, result = A - B - InputCarry. This is implemented as A + ~B + ~InputCarry.
//     In that case OutputCarry=1 means no borrow, and Overflow means signed subtract overflow.
//   BIT_SERIAL_ADDER_SUB_EN undefined:
//     No Subtract port; addition only; no extra logic.
// TESTING
//   WIDTH=8, BPC=1: A=0x00, B=0x00, Cin=0 -> Output=0x00, Carry=0, Ovf=0, OutputValid 9 clocks after accept.
//   A=0xFF, B=0xFF, Cin=1 -> Output=0xFF, Carry=1, Ovf=0.
//   A=0x7F, B=0x01, Cin=0 -> Output=0x80, Carry=0, Ovf=1.
//   A=0xAA, B=0x55, Cin=1 -> Output=0x00, Carry=1.
//     Then hold OutputReady=0 for 5 clocks -> outputs stable, InputReady=0.
//     Toggling InputValid with A=0x12 is ignored.
//   WIDTH=16, BPC=4: A=0x1234, B=0xEDCC, Cin=0 -> Output=0x0000, Carry=1, OutputValid 5 clocks after accept.
//     Pulse ResetN low at RUN cycle 2 -> outputs 0, InputReady=1 asynchronously.
//     A following add of 0x0001+0x0001 -> 0x0002.
//   SUB_EN, WIDTH=8: Subtract=1, A=0x05, B=0x07, Cin=0 -> Output=0xFE, Carry=0 (borrow).
//     A=0x80, B=0x01 -> Output=0x7F, Ovf=1.

Source files
------------

// File: rtl/bit_serial_adder_if.sv
// ---------------------------------------------------------------------------
// bit_serial_adder_if
//   Operand/result bus of the bit-serial adder.
//
//   Handshake rules (both channels):
//     A transfer happens on a rising Clock edge where Valid && Ready are both high.
//     The producer holds Valid and its payload stable until that transfer edge.
//     Ready may be asserted without Valid being asserted.
//     The adder's InputReady and OutputValid are registered outputs.
//
//   Signals:
//     InputValid  / InputReady   operand channel handshake
//     InputA, InputB, InputCarry operand payload (WIDTH, WIDTH, 1)
//     Subtract                   operation select, present only when
//                                BIT_SERIAL_ADDER_SUB_EN is defined
//     OutputValid / OutputReady  result channel handshake
//     Output, OutputCarry,
//     Overflow                   result payload (WIDTH, 1, 1)
//
//   Modports: master = operand producer / result consumer, slave = the adder.
// ---------------------------------------------------------------------------
interface bit_serial_adder_if #(
   parameter int WIDTH = 8
);
   logic             InputValid;
   logic             InputReady;
   logic [WIDTH-1:0] InputA;
   logic [WIDTH-1:0] InputB;
   logic             InputCarry;
`ifdef BIT_SERIAL_ADDER_SUB_EN
   logic             Subtract;
`endif
   logic             OutputValid;
   logic             OutputReady;
   logic [WIDTH-1:0] Output;
   logic             OutputCarry;
   logic             Overflow;

   modport master (
      output InputValid, InputA, InputB, InputCarry,
`ifdef BIT_SERIAL_ADDER_SUB_EN
      output Subtract,
`endif
      input  InputReady,
      output OutputReady,
      input  OutputValid, Output, OutputCarry, Overflow
   );

   modport slave (
      input  InputValid, InputA, InputB, InputCarry,
`ifdef BIT_SERIAL_ADDER_SUB_EN
      input  Subtract,
`endif
      output InputReady,
      input  OutputReady,
      output OutputValid, Output, OutputCarry, Overflow
   );
endinterface

// File: rtl/bit_serial_adder.sv
// ---------------------------------------------------------------------------
// bit_serial_adder
//   Parametrised bit-serial adder. Operands and carry-in are captured on the
//   input handshake, then summed BITS_PER_CYCLE bits per clock, LSB slice
//   first, through one slice adder. The sum, carry-out and signed overflow
//   are held on the result channel until the consumer accepts them.
//
//   Parameters:
//     WIDTH           operand/sum width (>= 2); must match the interface WIDTH
//     BITS_PER_CYCLE  slice width; must divide WIDTH
//
//   Ports:
//     Clock       in   rising-edge clock
//     ResetN      in   asynchronous active-low reset
//     bus         slave modport of bit_serial_adder_if (operands and result)
//     StateDebug  out  current FSM state (0 = IDLE, 1 = RUN, 2 = DONE)
//
//   Optional feature macro: BIT_SERIAL_ADDER_SUB_EN
//     Defined: bus.Subtract is captured with the operands; when set the block
//     computes A - B - InputCarry as A + ~B + ~InputCarry, so OutputCarry=1
//     means "no borrow". Undefined: addition only.
//
//   Timing: N = WIDTH/BITS_PER_CYCLE RUN cycles; OutputValid rises N+1
//   clocks after the accept edge (counting that edge); one result per N+2
//   clocks with OutputReady held high.
// ---------------------------------------------------------------------------
module bit_serial_adder #(
   parameter int WIDTH          = 8,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic                  Clock,
   input  logic                  ResetN,
   bit_serial_adder_if.slave     bus,
   output logic [1:0]            StateDebug
);
   localparam int BPC = BITS_PER_CYCLE;
   localparam int N   = WIDTH / BPC;
   localparam int CW  = (N > 1) ? $clog2(N) : 1;

   generate
      if (WIDTH < 2 || (WIDTH % BPC) != 0) begin : gParamCheck
         $error("bit_serial_adder: WIDTH must be >= 2 and divisible by BITS_PER_CYCLE");
      end
   endgenerate

   typedef enum logic [1:0] {
      Idle = 2'd0,
      Run  = 2'd1,
      Done = 2'd2
   } stateT;

   stateT            state;
   logic [WIDTH-1:0] opA;        // shifted right one slice per RUN cycle
   logic [WIDTH-1:0] opB;
   logic             runCarry;   // carry between slices
   logic [WIDTH-1:0] sumReg;     // slices enter at the MSB end
   logic [CW-1:0]    count;

   // Subtraction is folded into the capture: B is inverted and the carry-in
   // complemented once, so the slice datapath is identical for both modes.
   logic [WIDTH-1:0] opBIn;
   logic             carryIn;
`ifdef BIT_SERIAL_ADDER_SUB_EN
   assign opBIn   = bus.InputB ^ {WIDTH{bus.Subtract}};
   assign carryIn = bus.InputCarry ^ bus.Subtract;
`else
   assign opBIn   = bus.InputB;
   assign carryIn = bus.InputCarry;
`endif

   // Slice adder
   logic [BPC-1:0]     aSlice;
   logic [BPC-1:0]     bSlice;
   logic [BPC:0]       sliceFull;
   logic               carryIntoMsb;
   logic [WIDTH+BPC-1:0] shifted;
   logic [WIDTH-1:0]   nextSum;
   logic               lastSlice;

   assign aSlice    = opA[BPC-1:0];
   assign bSlice    = opB[BPC-1:0];
   assign sliceFull = {1'b0, aSlice} + {1'b0, bSlice} + {{BPC{1'b0}}, runCarry};
   // Carry into the top bit of the slice recovered from that bit's sum:
   // s = a ^ b ^ cin  =>  cin = a ^ b ^ s. Only meaningful on the last slice.
   assign carryIntoMsb = aSlice[BPC-1] ^ bSlice[BPC-1] ^ sliceFull[BPC-1];
   assign shifted   = {sliceFull[BPC-1:0], sumReg};
   assign nextSum   = shifted[WIDTH+BPC-1:BPC];
   assign lastSlice = (count == CW'(N - 1));

   assign StateDebug = state;

   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         state           <= Idle;
         opA             <= '0;
         opB             <= '0;
         runCarry        <= 1'b0;
         sumReg          <= '0;
         count           <= '0;
         bus.InputReady  <= 1'b1;
         bus.OutputValid <= 1'b0;
         bus.Output      <= '0;
         bus.OutputCarry <= 1'b0;
         bus.Overflow    <= 1'b0;
      end else begin
         case (state)
            Idle: begin
               // InputReady is high throughout IDLE, so InputValid alone
               // marks the transfer edge.
               if (bus.InputValid) begin
                  opA            <= bus.InputA;
                  opB            <= opBIn;
                  runCarry       <= carryIn;
                  count          <= '0;
                  bus.InputReady <= 1'b0;
                  state          <= Run;
               end
            end
            Run: begin
               opA      <= opA >> BPC;
               opB      <= opB >> BPC;
               runCarry <= sliceFull[BPC];
               sumReg   <= nextSum;
               count    <= count + CW'(1);
               if (lastSlice) begin
                  count           <= '0;
                  bus.Output      <= nextSum;
                  bus.OutputCarry <= sliceFull[BPC];
                  bus.Overflow    <= carryIntoMsb ^ sliceFull[BPC];
                  bus.OutputValid <= 1'b1;
                  state           <= Done;
               end
            end
            Done: begin
               // InputReady rises only after this edge, so no operand can be
               // taken on the DONE->IDLE edge itself.
               if (bus.OutputReady) begin
                  bus.OutputValid <= 1'b0;
                  bus.InputReady  <= 1'b1;
                  state           <= Idle;
               end
            end
            default: begin
               bus.OutputValid <= 1'b0;
               bus.InputReady  <= 1'b1;
               state           <= Idle;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_bit_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_bit_serial_adder
//   Two adder instances: 8-bit/1 bit per cycle and 16-bit/4 bits per cycle.
//   Known vectors from a table, backpressure / reset / throughput sequences,
//   then random operands against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_bit_serial_adder;
   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rstN8;
   logic rstN16;
   always #5 clk = ~clk;

   bit_serial_adder_if #(.WIDTH(8))  bus8 ();
   bit_serial_adder_if #(.WIDTH(16)) bus16 ();
   logic [1:0] dbg8;
   logic [1:0] dbg16;

   bit_serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut8 (
      .Clock      (clk),
      .ResetN     (rstN8),
      .bus        (bus8.slave),
      .StateDebug (dbg8)
   );

   bit_serial_adder #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut16 (
      .Clock      (clk),
      .ResetN     (rstN16),
      .bus        (bus16.slave),
      .StateDebug (dbg16)
   );

   int checks = 0;
   int errors = 0;

   // ---------------- scoreboard ----------------
   logic [17:0] expQ[$];   // {sum, carry, overflow}

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: plain integer arithmetic on the operand values.
   function automatic void refModel(input int w, input logic [15:0] a, input logic [15:0] b,
                                    input logic cin, input logic sub,
                                    output logic [15:0] sum, output logic co, output logic ovf);
      longint one  = 1;
      longint span = one << w;
      longint half = one << (w - 1);
      longint ua   = longint'(a);
      longint ub   = longint'(b);
      longint c    = cin ? 1 : 0;
      longint sa   = (ua >= half) ? ua - span : ua;
      longint sb   = (ub >= half) ? ub - span : ub;
      longint full;
      longint sres;
      if (!sub) begin
         full = ua + ub + c;
         co   = (full >= span);
         sres = sa + sb + c;
      end else begin
         full = ua - ub - c;
         co   = (ua >= ub + c);   // carry set means no borrow
         sres = sa - sb - c;
      end
      sum = 16'(full & (span - 1));
      ovf = (sres >= half) || (sres < -half);
   endfunction

   // ---------------- driver helpers ----------------
   logic sub8 = 1'b0;
   logic sub16 = 1'b0;
`ifdef BIT_SERIAL_ADDER_SUB_EN
   assign bus8.Subtract  = sub8;
   assign bus16.Subtract = sub16;
`endif

   task automatic driveIn(input int sel, input logic valid, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub);
      if (sel == 8) begin
         bus8.InputValid = valid;
         bus8.InputA     = a[7:0];
         bus8.InputB     = b[7:0];
         bus8.InputCarry = cin;
         sub8            = sub;
      end else begin
         bus16.InputValid = valid;
         bus16.InputA     = a;
         bus16.InputB     = b;
         bus16.InputCarry = cin;
         sub16            = sub;
      end
   endtask

   task automatic setReady(input int sel, input logic v);
      if (sel == 8) bus8.OutputReady = v;
      else          bus16.OutputReady = v;
   endtask

   function automatic logic inReady(input int sel);
      return (sel == 8) ? bus8.InputReady : bus16.InputReady;
   endfunction
   function automatic logic outValid(input int sel);
      return (sel == 8) ? bus8.OutputValid : bus16.OutputValid;
   endfunction
   function automatic logic [15:0] outSum(input int sel);
      return (sel == 8) ? {8'h00, bus8.Output} : bus16.Output;
   endfunction
   function automatic logic outCarry(input int sel);
      return (sel == 8) ? bus8.OutputCarry : bus16.OutputCarry;
   endfunction
   function automatic logic outOvf(input int sel);
      return (sel == 8) ? bus8.Overflow : bus16.Overflow;
   endfunction

   // One full transaction. lat counts clocks from the accept edge (as 1)
   // to the first sample with OutputValid high; capped at 100.
   task automatic doOp(input int sel, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic sub, input int hold,
                       output logic [15:0] sum, output logic co, output logic ovf, output int lat);
      int guard = 0;
      while (!inReady(sel) && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      check("ready_before_op", 32'(inReady(sel)), 32'd1);
      driveIn(sel, 1'b1, a, b, cin, sub);
      @(posedge clk); #1;
      // Junk on the operand pins after acceptance must not matter.
      driveIn(sel, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
      lat = 1;
      while (!outValid(sel) && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      sum = outSum(sel);
      co  = outCarry(sel);
      ovf = outOvf(sel);
      repeat (hold) begin
         @(posedge clk); #1;
      end
      setReady(sel, 1'b1);
      @(posedge clk); #1;
      setReady(sel, 1'b0);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      int          sel;
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic        sub;
      logic [15:0] expSum;
      logic        expCo;
      logic        expOvf;
      int          expLat;
   } vecT;

   vecT vecs[$];

   initial begin
      #20000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] sum;
      logic        co;
      logic        ovf;
      int          lat;
      int          first;
      int          second;
      int          sawValid;
      logic [15:0] seen;

      vecs.push_back('{8,  16'h00,   16'h00,   1'b0, 1'b0, 16'h00,   1'b0, 1'b0, 9});
      vecs.push_back('{8,  16'hFF,   16'hFF,   1'b1, 1'b0, 16'hFF,   1'b1, 1'b0, 9});
      vecs.push_back('{8,  16'h7F,   16'h01,   1'b0, 1'b0, 16'h80,   1'b0, 1'b1, 9});
      vecs.push_back('{8,  16'hAA,   16'h55,   1'b1, 1'b0, 16'h00,   1'b1, 1'b0, 9});
      vecs.push_back('{8,  16'h80,   16'h80,   1'b0, 1'b0, 16'h00,   1'b1, 1'b1, 9});
      vecs.push_back('{16, 16'h1234, 16'hEDCC, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 5});
      vecs.push_back('{16, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 5});
`ifdef BIT_SERIAL_ADDER_SUB_EN
      vecs.push_back('{8,  16'h05,   16'h07,   1'b0, 1'b1, 16'hFE,   1'b0, 1'b0, 9});
      vecs.push_back('{8,  16'h80,   16'h01,   1'b0, 1'b1, 16'h7F,   1'b1, 1'b1, 9});
`endif

      // ---- reset ----
      rstN8  = 1'b0;
      rstN16 = 1'b0;
      driveIn(8, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      driveIn(16, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      setReady(8, 1'b0);
      setReady(16, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      for (int s = 8; s <= 16; s += 8) begin
         check("reset_in_ready",  32'(inReady(s)),  32'd1);
         check("reset_out_valid", 32'(outValid(s)), 32'd0);
         check("reset_sum",       32'(outSum(s)),   32'd0);
         check("reset_carry",     32'(outCarry(s)), 32'd0);
         check("reset_ovf",       32'(outOvf(s)),   32'd0);
      end
      rstN8  = 1'b1;
      rstN16 = 1'b1;
      @(posedge clk); #1;

      // ---- table ----
      foreach (vecs[i]) begin
         doOp(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, i % 3, sum, co, ovf, lat);
         check("vec_sum",     32'(sum), 32'(vecs[i].expSum));
         check("vec_carry",   32'(co),  32'(vecs[i].expCo));
         check("vec_ovf",     32'(ovf), 32'(vecs[i].expOvf));
         check("vec_latency", 32'(lat), 32'(vecs[i].expLat));
      end

      // ---- backpressure: hold DONE, toggle InputValid with other operands ----
      driveIn(8, 1'b1, 16'hAA, 16'h55, 1'b1, 1'b0);
      @(posedge clk); #1;
      driveIn(8, 1'b0, 16'hAA, 16'h55, 1'b1, 1'b0);
      lat = 1;
      while (!bus8.OutputValid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      check("bp_latency", 32'(lat), 32'd9);
      for (int i = 0; i < 5; i++) begin
         driveIn(8, 1'(i % 2 == 0), 16'h12, 16'h34, 1'b0, 1'b0);
         @(posedge clk); #1;
         check("bp_sum",       32'(bus8.Output),      32'h00);
         check("bp_carry",     32'(bus8.OutputCarry), 32'd1);
         check("bp_valid",     32'(bus8.OutputValid), 32'd1);
         check("bp_in_ready",  32'(bus8.InputReady),  32'd0);
      end
      driveIn(8, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      setReady(8, 1'b1);
      @(posedge clk); #1;
      setReady(8, 1'b0);
      check("bp_release_valid", 32'(bus8.OutputValid), 32'd0);
      check("bp_release_ready", 32'(bus8.InputReady),  32'd1);
      sawValid = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (bus8.OutputValid) sawValid++;
      end
      check("bp_no_resample", 32'(sawValid), 32'd0);

      // ---- throughput with both handshakes held high ----
      driveIn(8, 1'b1, 16'h03, 16'h04, 1'b0, 1'b0);
      setReady(8, 1'b1);
      first  = -1;
      second = -1;
      seen   = '0;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk); #1;
         if (bus8.OutputValid) begin
            seen = {8'h00, bus8.Output};
            if (first < 0) first = c;
            else if (second < 0) second = c;
         end
      end
      check("throughput_period", 32'(second - first), 32'd10);
      check("throughput_sum",    32'(seen),           32'd7);
      driveIn(8, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      repeat (15) @(posedge clk);
      #1;
      setReady(8, 1'b0);

      // ---- random against the reference model ----
      for (int s = 8; s <= 16; s += 8) begin
         for (int i = 0; i < 30; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            logic        rc;
            logic        rs;
            logic [17:0] e;
            ra = 16'($urandom_range(0, (s == 8) ? 255 : 65535));
            rb = 16'($urandom_range(0, (s == 8) ? 255 : 65535));
            rc = 1'($urandom_range(0, 1));
`ifdef BIT_SERIAL_ADDER_SUB_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            refModel(s, ra, rb, rc, rs, sum, co, ovf);
            expQ.push_back({sum, co, ovf});
            doOp(s, ra, rb, rc, rs, $urandom_range(0, 3), sum, co, ovf, lat);
            e = expQ.pop_front();
            check("rand_result",  32'({sum, co, ovf}), 32'(e));
            check("rand_latency", 32'(lat), (s == 8) ? 32'd9 : 32'd5);
         end
      end

      // ---- asynchronous reset in the middle of RUN ----
      doOp(16, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, sum, co, ovf, lat);
      check("pre_reset_sum", 32'(sum), 32'h8000);
      driveIn(16, 1'b1, 16'h1111, 16'h2222, 1'b1, 1'b0);
      @(posedge clk); #1;
      driveIn(16, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("run_in_ready", 32'(bus16.InputReady), 32'd0);
      rstN16 = 1'b0;
      #1;
      check("async_rst_sum",      32'(bus16.Output),      32'd0);
      check("async_rst_ovf",      32'(bus16.Overflow),    32'd0);
      check("async_rst_carry",    32'(bus16.OutputCarry), 32'd0);
      check("async_rst_valid",    32'(bus16.OutputValid), 32'd0);
      check("async_rst_in_ready", 32'(bus16.InputReady),  32'd1);
      #2;
      rstN16 = 1'b1;
      @(posedge clk); #1;
      doOp(16, 16'h0001, 16'h0001, 1'b0, 1'b0, 1, sum, co, ovf, lat);
      check("post_reset_sum",     32'(sum), 32'h0002);
      check("post_reset_carry",   32'(co),  32'd0);
      check("post_reset_latency", 32'(lat), 32'd5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
